// File: rtl/cmd_dispatch_and_response_collect.sv
// Serialising command dispatcher: forwards one config/status command to the addressed target
// and returns its read response, or ERR_DATA on timeout / unmapped target.
module cmd_dispatch_and_response_collect #(
    parameter int          NUM_TGT     = 4,
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [18:0]          iv_addr,
    input  logic                 i_addr_fixed,
    input  logic [31:0]          iv_wdata,
    input  logic                 i_wr,
    input  logic                 i_rd,
    output logic                 o_busy,
    output logic                 o_wr_rsp,
    output logic [18:0]          ov_addr_rsp,
    output logic                 o_addr_fixed_rsp,
    output logic [31:0]          ov_rdata_rsp,
    output logic [18:0]          ov_addr_tgt,
    output logic                 o_addr_fixed_tgt,
    output logic [31:0]          ov_wdata_tgt,
    output logic [NUM_TGT-1:0]   ov_wr_tgt,
    output logic [NUM_TGT-1:0]   ov_rd_tgt,
    input  logic [NUM_TGT-1:0]   iv_wr_rsp_tgt,
    input  logic [32*NUM_TGT-1:0] iv_rdata_tgt,
    output logic                 o_timeout_pulse,
    output logic [15:0]          ov_timeout_cnt
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [18:0] addr;
        logic        fixed;
        logic [31:0] wdata;
        logic        is_wr;
        logic        mapped;
        logic [2:0]  sel;
    } cmd_t;

    state_t       state, state_next;
    cmd_t         cmd_q, cmd_next;
    logic [31:0]  rdata_q, rdata_next;
    logic [15:0]  wait_cnt, wait_next;
    logic         timeout_hit;

    logic [2:0]          sel_in;
    logic                mapped_in;
    logic                rsp_hit;
    logic [31:0]         rsp_data;
    logic [NUM_TGT-1:0]  tgt_onehot;

    assign sel_in    = iv_addr[18:16];
    assign mapped_in = int'(sel_in) < NUM_TGT;

    // Pick the awaited target's response; other targets' responses never reach the FSM.
    always_comb begin
        rsp_hit  = 1'b0;
        rsp_data = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            if (cmd_q.sel == 3'(k)) begin
                rsp_hit  = iv_wr_rsp_tgt[k];
                rsp_data = iv_rdata_tgt[32*k +: 32];
            end
        end
    end

    // An unmapped select matches no k, so the one-hot stays zero.
    always_comb begin
        tgt_onehot = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            tgt_onehot[k] = (cmd_next.sel == 3'(k));
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next  = state;
        cmd_next    = cmd_q;
        rdata_next  = rdata_q;
        wait_next   = wait_cnt;
        timeout_hit = 1'b0;

        unique case (state)
            IDLE: begin
                // Write wins over a simultaneous read; unmapped writes are dropped silently.
                if ((i_wr && mapped_in) || (!i_wr && i_rd)) begin
                    cmd_next.addr   = iv_addr;
                    cmd_next.fixed  = i_addr_fixed;
                    cmd_next.wdata  = iv_wdata;
                    cmd_next.is_wr  = i_wr;
                    cmd_next.mapped = mapped_in;
                    cmd_next.sel    = sel_in;
                    state_next      = ISSUE;
                    if (!mapped_in) begin
                        rdata_next = ERR_DATA;
                    end
                end
            end
            ISSUE: begin
                // Unmapped reads pass through ISSUE with no target pulse, answering at T+2.
                if (cmd_q.is_wr) begin
                    state_next = IDLE;
                end else if (!cmd_q.mapped) begin
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                    wait_next  = 16'd1;
                end
            end
            WAIT: begin
                if (rsp_hit) begin
                    rdata_next = rsp_data;
                    state_next = RESP;
                end else if (wait_cnt == TIMEOUT_LIM) begin
                    rdata_next  = ERR_DATA;
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end else begin
                    wait_next = wait_cnt + 16'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they align with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            cmd_q            <= '0;
            rdata_q          <= '0;
            wait_cnt         <= '0;
            o_busy           <= 1'b0;
            o_wr_rsp         <= 1'b0;
            ov_addr_rsp      <= '0;
            o_addr_fixed_rsp <= 1'b0;
            ov_rdata_rsp     <= '0;
            ov_addr_tgt      <= '0;
            o_addr_fixed_tgt <= 1'b0;
            ov_wdata_tgt     <= '0;
            ov_wr_tgt        <= '0;
            ov_rd_tgt        <= '0;
            o_timeout_pulse  <= 1'b0;
            ov_timeout_cnt   <= '0;
        end else begin
            state    <= state_next;
            cmd_q    <= cmd_next;
            rdata_q  <= rdata_next;
            wait_cnt <= wait_next;

            o_busy <= (state_next != IDLE);

            if (state_next == ISSUE) begin
                ov_addr_tgt      <= cmd_next.addr;
                o_addr_fixed_tgt <= cmd_next.fixed;
                ov_wdata_tgt     <= cmd_next.wdata;
                ov_wr_tgt        <= cmd_next.is_wr ? tgt_onehot : '0;
                ov_rd_tgt        <= cmd_next.is_wr ? '0 : tgt_onehot;
            end else begin
                ov_addr_tgt      <= '0;
                o_addr_fixed_tgt <= 1'b0;
                ov_wdata_tgt     <= '0;
                ov_wr_tgt        <= '0;
                ov_rd_tgt        <= '0;
            end

            if (state_next == RESP) begin
                o_wr_rsp         <= 1'b1;
                ov_addr_rsp      <= cmd_next.addr;
                o_addr_fixed_rsp <= cmd_next.fixed;
                ov_rdata_rsp     <= rdata_next;
            end else begin
                o_wr_rsp         <= 1'b0;
                ov_addr_rsp      <= '0;
                o_addr_fixed_rsp <= 1'b0;
                ov_rdata_rsp     <= '0;
            end

            o_timeout_pulse <= timeout_hit;
            if (timeout_hit && (ov_timeout_cnt != 16'hFFFF)) begin
                ov_timeout_cnt <= ov_timeout_cnt + 16'd1;
            end
        end
    end

endmodule
